// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide controller for the EX stage.
// Accepts one mult/multu/div/divu/mthi/mtlo command, latches the operands,
// models unit latency with a down-counter and owns the HI/LO registers.
//
// State table:
//   IDLE | waiting for a command; MTHI/MTLO complete here in one cycle
//   BUSY | mult/div in flight; counter runs down to 0, then HI/LO update
//
// Ports:
//   clk        system clock (rising edge)
//   reset      synchronous active-high reset
//   start      command valid this cycle
//   md_op      0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//   rs_val     operand A (dividend / multiplicand / move source)
//   rt_val     operand B (divisor / multiplier)
//   md_use_d   D-stage instruction uses the MD unit
//   busy       registered, unit computing
//   stall_req  combinational D-stage stall
//   hi_out     HI register
//   lo_out     LO register
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;

  logic               is_calc;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        div_bs;
  logic [31:0]        div_bu;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [63:0]        res;
  logic               res_wr;

  assign is_calc   = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign stall_req = md_use_d & (busy | (start & is_calc));

  // Result datapath from the latched operands. Divisors are steered to 1 for
  // divide-by-zero (result discarded) and for the signed overflow case, where
  // dividing by 1 yields exactly the required quotient 0x80000000, remainder 0.
  always_comb begin
    prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    div_zero = (b_q == 32'd0);
    div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    div_bs   = (div_zero || div_ovf) ? 32'd1 : b_q;
    div_bu   = div_zero ? 32'd1 : b_q;
    q_s      = $signed(a_q) / $signed(div_bs);
    r_s      = $signed(a_q) % $signed(div_bs);
    q_u      = a_q / div_bu;
    r_u      = a_q % div_bu;
    res      = {hi_out, lo_out};
    res_wr   = 1'b0;
    case (op_q)
      OP_MULT:  begin res = prod_s;     res_wr = 1'b1;      end
      OP_MULTU: begin res = prod_u;     res_wr = 1'b1;      end
      OP_DIV:   begin res = {r_s, q_s}; res_wr = !div_zero; end
      OP_DIVU:  begin res = {r_u, q_u}; res_wr = !div_zero; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_calc) begin
              op_q  <= md_op;
              a_q   <= rs_val;
              b_q   <= rt_val;
              cnt   <= (md_op == OP_MULT || md_op == OP_MULTU) ?
                       CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
              state <= BUSY;
              busy  <= 1'b1;
            end else if (md_op == OP_MTHI) begin
              hi_out <= rs_val;
            end else if (md_op == OP_MTLO) begin
              lo_out <= rs_val;
            end
          end
        end
        BUSY: begin
          // Commands arriving here are ignored; upstream stall prevents them.
          if (cnt == '0) begin
            if (res_wr) begin
              hi_out <= res[63:32];
              lo_out <= res[31:0];
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        md_use_d = 1'b0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  always #5 clk = ~clk;

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
    .busy(busy), .stall_req(stall_req), .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct {
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [31:0] new_hi;
    logic [31:0] new_lo;
    int          n;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passes = 0;
  bit          aborted = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: architectural HI/LO effect of one command.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output bit calc);
    exp_t e;
    longint sp;
    longint unsigned up;
    int sa, sb;
    calc = 1'b0;
    n = 0;
    e.old_hi = m_hi;
    e.old_lo = m_lo;
    case (op)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = sp; calc = 1; n = MC; end
      3'd2: begin up = 64'(a) * 64'(b); {m_hi, m_lo} = up; calc = 1; n = MC; end
      3'd3: begin
        calc = 1; n = DC;
        sa = $signed(a); sb = $signed(b);
        if (b == 32'd0) ;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 32'd0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
      end
      3'd4: begin
        calc = 1; n = DC;
        if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
    if (calc) begin
      e.new_hi = m_hi;
      e.new_lo = m_lo;
      e.n = n;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: a falling busy is the unit presenting a result.
  initial begin
    bit   prev;
    int   len;
    bit   held;
    exp_t e;
    prev = 0; len = 0; held = 1;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!prev) begin len = 0; held = 1; end
        len++;
        if (sb_q.size() > 0 && (hi_out !== sb_q[0].old_hi || lo_out !== sb_q[0].old_lo)) held = 0;
      end else if (prev) begin
        if (aborted) aborted = 0;
        else if (sb_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("busy_len", 64'(len), 64'(e.n));
          chk("hilo_held", 64'(held), 64'd1);
          chk("hi_result", 64'(hi_out), 64'(e.new_hi));
          chk("lo_result", 64'(lo_out), 64'(e.new_lo));
        end
      end
      prev = busy;
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit use_d);
    int n;
    bit calc;
    int sc;
    @(negedge clk);
    start = 1; md_op = op; rs_val = a; rt_val = b; md_use_d = use_d;
    #1 sc = int'(stall_req);
    model_op(op, a, b, n, calc);
    @(posedge clk);
    #1 start = 0; md_op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
    if (calc) begin
      for (int i = 1; i <= n + 2; i++) begin
        @(negedge clk);
        sc += int'(stall_req);
        if (i == 2 && n >= 3) begin
          start = 1; md_op = 3'($urandom_range(1, 6)); rs_val = $urandom;
        end
        if (i == 3) start = 0;
      end
      chk("stall_cycles", 64'(sc), use_d ? 64'(n + 1) : 64'd0);
    end else begin
      @(negedge clk);
      chk("stall_nocalc", 64'(sc), 64'd0);
      chk("busy_nocalc", 64'(busy), 64'd0);
      chk("hi_nocalc", 64'(hi_out), 64'(m_hi));
      chk("lo_nocalc", 64'(lo_out), 64'(m_lo));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int sel;
    md_use_d = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    reset = 0;

    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1);
    do_op(3'd4, 32'd7, 32'd0, 0);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    do_op(3'd3, 32'd100, 32'd0, 1);

    // Back-to-back MTHI then MTLO.
    @(negedge clk);
    start = 1; md_op = 3'd5; rs_val = 32'h1234_5678; md_use_d = 1;
    @(posedge clk);
    #1 md_op = 3'd6; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mthi_hi", 64'(hi_out), 64'h1234_5678);
    chk("mthi_lo", 64'(lo_out), 64'(m_lo));
    chk("mthi_busy", 64'(busy), 64'd0);
    m_hi = 32'h1234_5678;
    @(posedge clk);
    #1 start = 0;
    m_lo = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("mtlo_lo", 64'(lo_out), 64'(m_lo));
    chk("mtlo_hi", 64'(hi_out), 64'(m_hi));
    chk("mtlo_busy", 64'(busy), 64'd0);

    // Reset in the 3rd busy cycle of a MULT.
    do_op(3'd5, 32'h11, 32'd0, 0);
    do_op(3'd6, 32'h22, 32'd0, 0);
    @(negedge clk);
    start = 1; md_op = 3'd1; rs_val = 32'd9; rt_val = 32'd9;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    chk("abort_hi_before", 64'(hi_out), 64'h11);
    aborted = 1; reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    m_hi = 0; m_lo = 0;
    do_op(3'd1, 32'd4, 32'd5, 1);

    // Reset and start together: reset wins.
    do_op(3'd5, 32'hDEAD_BEEF, 32'd0, 0);
    @(negedge clk);
    reset = 1; start = 1; md_op = 3'd3; rs_val = 32'd50; rt_val = 32'd7;
    @(posedge clk);
    #1 reset = 0; start = 0;
    m_hi = 0; m_lo = 0;
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_hi", 64'(hi_out), 64'd0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
      do_op(3'($urandom_range(0, 7)), a, b, 1'($urandom));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
